// File: rtl/stop_watch.sv
// Minutes:seconds stopwatch with run/pause/clear control.
// Ack is high whenever the watch is not running.
module stop_watch #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_watch_en,
  input  logic       start_stop_button,
  input  logic       clear_button,
  output logic [5:0] stop_watch_minutes,
  output logic [5:0] stop_watch_seconds,
  output logic       stop_watch_ack_flag,
  output logic       stop_watch_running,
  output logic       stop_watch_wrap
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] P_LAST =
    PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED
  } state_t;

  state_t          state_q, state_d;
  logic            ss_q, clr_q;
  logic            ss_press, clr_press;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0]      min_d, sec_d;
  logic            wrap_d;
  logic            tick;

  assign ss_press  = start_stop_button & ~ss_q;
  assign clr_press = clear_button & ~clr_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick    = 1'b0;
    if (stop_watch_en) begin
      if (clr_press) begin
        state_d = IDLE;
        presc_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_press) begin
              state_d = RUNNING;
              presc_d = '0;
            end
          end
          RUNNING: begin
            if (ss_press) state_d = PAUSED;
            if (presc_q == P_LAST) begin
              presc_d = '0;
              tick    = 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
          PAUSED: begin
            if (ss_press) state_d = RUNNING;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Clear wins; otherwise a tick advances the count.
  always_comb begin
    min_d  = stop_watch_minutes;
    sec_d  = stop_watch_seconds;
    wrap_d = 1'b0;
    if (stop_watch_en && clr_press) begin
      min_d = '0;
      sec_d = '0;
    end else if (tick) begin
      if (stop_watch_seconds == 6'd59) begin
        sec_d = '0;
        if (stop_watch_minutes == 6'd59) begin
          min_d  = '0;
          wrap_d = 1'b1;
        end else begin
          min_d = stop_watch_minutes + 6'd1;
        end
      end else begin
        sec_d = stop_watch_seconds + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      presc_q            <= '0;
      ss_q               <= 1'b0;
      clr_q              <= 1'b0;
      stop_watch_minutes <= '0;
      stop_watch_seconds <= '0;
      stop_watch_wrap    <= 1'b0;
    end else begin
      state_q            <= state_d;
      presc_q            <= presc_d;
      ss_q               <= start_stop_button;
      clr_q              <= clear_button;
      stop_watch_minutes <= min_d;
      stop_watch_seconds <= sec_d;
      stop_watch_wrap    <= wrap_d;
    end
  end

  assign stop_watch_ack_flag = (state_q != RUNNING);
  assign stop_watch_running  = (state_q == RUNNING);

endmodule

// File: tb/tb_stop_watch.sv
// Bench for stop_watch: vector table, directed corners, and
// random stimulus against an elapsed-cycles reference model.
module tb_stop_watch;

  localparam int T = 4;

  logic       clk, rst, en, ss, clr;
  logic [5:0] mins, secs;
  logic       ack, run, wrap;

  int n_chk;
  int n_fail;

  int m_cyc;
  bit m_run, m_wrap, m_ssp, m_clp;

  typedef struct {
    logic       en, ss, clr;
    logic [5:0] sec;
    logic       run;
  } vec_t;

  vec_t tbl[17];

  stop_watch #(.TICKS_PER_SEC(T)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stop_watch_en       (en),
    .start_stop_button   (ss),
    .clear_button        (clr),
    .stop_watch_minutes  (mins),
    .stop_watch_seconds  (secs),
    .stop_watch_ack_flag (ack),
    .stop_watch_running  (run),
    .stop_watch_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] dut_pack();
    return {mins, secs, ack, run, wrap};
  endfunction

  function automatic logic [14:0] exp_pack(
    int m, int s, bit r, bit w);
    return {6'(m), 6'(s), ~r, r, w};
  endfunction

  function automatic logic [14:0] model_pack();
    return exp_pack((m_cyc / T / 60) % 60,
                    (m_cyc / T) % 60, m_run, m_wrap);
  endfunction

  task automatic check(input string name,
                       input logic [14:0] act,
                       input logic [14:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_run  = 0;
    m_wrap = 0;
    m_ssp  = 0;
    m_clp  = 0;
  endtask

  // Elapsed run-cycles model: display is derived by division.
  task automatic model_edge(input bit e, input bit s,
                            input bit c);
    m_wrap = 0;
    if (e) begin
      if (c && !m_clp) begin
        m_cyc = 0;
        m_run = 0;
      end else if (m_run) begin
        m_cyc++;
        m_wrap = (m_cyc % (3600 * T)) == 0;
        if (s && !m_ssp) m_run = 0;
      end else if (s && !m_ssp) begin
        m_run = 1;
      end
    end
    m_ssp = s;
    m_clp = c;
  endtask

  task automatic step(input bit e, input bit s,
                      input bit c);
    en  = e;
    ss  = s;
    clr = c;
    @(posedge clk);
    model_edge(e, s, c);
    #1;
    check("model", dut_pack(), model_pack());
  endtask

  task automatic set_row(input int i, input bit e,
                         input bit s, input bit c,
                         input int sc, input bit r);
    tbl[i].en  = e;
    tbl[i].ss  = s;
    tbl[i].clr = c;
    tbl[i].sec = 6'(sc);
    tbl[i].run = r;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    set_row(0,  1, 1, 0, 0, 1);
    set_row(1,  1, 0, 0, 0, 1);
    set_row(2,  1, 0, 0, 0, 1);
    set_row(3,  1, 0, 0, 0, 1);
    set_row(4,  1, 0, 0, 1, 1);
    set_row(5,  1, 1, 0, 1, 0);
    set_row(6,  1, 0, 0, 1, 0);
    set_row(7,  1, 1, 0, 1, 1);
    set_row(8,  1, 0, 0, 1, 1);
    set_row(9,  1, 0, 0, 1, 1);
    set_row(10, 1, 0, 0, 2, 1);
    set_row(11, 0, 1, 0, 2, 1);
    set_row(12, 0, 0, 0, 2, 1);
    set_row(13, 1, 0, 0, 2, 1);
    set_row(14, 1, 1, 1, 0, 0);
    set_row(15, 1, 0, 0, 0, 0);
    set_row(16, 1, 1, 0, 0, 1);

    rst = 1'b1;
    en  = 1'b0;
    ss  = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_pack(), exp_pack(0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].en, tbl[i].ss, tbl[i].clr);
      check($sformatf("tbl%0d", i), dut_pack(),
            exp_pack(0, tbl[i].sec, tbl[i].run, 0));
    end

    // Start: first seconds and the first minute.
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    check("start_ack", dut_pack(), exp_pack(0, 0, 1, 0));
    for (int k = 1; k <= 240; k++) begin
      step(1, 0, 0);
      if (k == 4)
        check("start_4", dut_pack(), exp_pack(0, 1, 1, 0));
      if (k == 8)
        check("start_8", dut_pack(), exp_pack(0, 2, 1, 0));
      if (k == 240)
        check("start_240", dut_pack(), exp_pack(1, 0, 1, 0));
    end

    // Asynchronous reset while running at 00:07.
    step(1, 0, 1);
    step(1, 1, 0);
    repeat (28) step(1, 0, 0);
    check("pre_rst", dut_pack(), exp_pack(0, 7, 1, 0));
    #2 rst = 1'b1;
    #1;
    check("async_rst", dut_pack(), exp_pack(0, 0, 0, 0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Pause at 00:03 with two prescaler cycles, then resume.
    step(1, 1, 0);
    repeat (13) step(1, 0, 0);
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    check("paused", dut_pack(), exp_pack(0, 3, 0, 0));
    step(1, 1, 0);
    step(1, 0, 0);
    check("resume_1", dut_pack(), exp_pack(0, 3, 1, 0));
    step(1, 0, 0);
    check("resume_2", dut_pack(), exp_pack(0, 4, 1, 0));

    // Clear and start_stop rising together at 00:05.
    repeat (4) step(1, 0, 0);
    check("pre_clr", dut_pack(), exp_pack(0, 5, 1, 0));
    step(1, 1, 1);
    check("clr_prio", dut_pack(), exp_pack(0, 0, 0, 0));

    // Enable gating at 00:02.
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (8) step(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, (k % 3) == 0, (k % 5) == 0);
      check("frozen", dut_pack(), exp_pack(0, 2, 1, 0));
    end
    repeat (3) step(0, 1, 0);
    repeat (3) step(1, 1, 0);
    check("held_ss", {14'd0, run}, 15'd1);
    step(1, 0, 0);

    // Rollover 59:59 -> 00:00.
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (3600 * T - 1) step(1, 0, 0);
    check("at_5959", dut_pack(), exp_pack(59, 59, 1, 0));
    step(1, 0, 0);
    check("wrap", dut_pack(), exp_pack(0, 0, 1, 1));
    step(1, 0, 0);
    check("wrap_end", dut_pack(), exp_pack(0, 0, 1, 0));

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 8) != 0,
           ($urandom % 6) == 0,
           ($urandom % 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
